systolic_array_nxn: RTL and testbench



---
 rtl/systolic_array_nxn_if.sv | 33 +++
 rtl/systolic_array_nxn.sv | 217 +++++++++++++++++++++
 tb/tb_systolic_array_nxn.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_array_nxn_if.sv
// Job-control, operand-stream and result handshake bundle for systolic_array_nxn.
// The master drives jobs and operands; the slave is the array.
interface systolic_array_nxn_if #(
    parameter int unsigned N      = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned K_MAX  = 16,
    parameter int unsigned ACC_W  = 20
);
    localparam int unsigned KW = $clog2(K_MAX + 1);

    logic                      enable;
    logic                      start;
    logic [KW-1:0]             k_len;
    logic                      busy;
    logic                      in_valid;
    logic                      in_ready;
    logic [N*DATA_W-1:0]       a_col;
    logic [N*DATA_W-1:0]       b_row;
    logic                      out_valid;
    logic                      out_ready;
    logic [N*N*ACC_W-1:0]      c_flat;
    logic                      ovf;

    modport master (
        output enable, start, k_len, in_valid, a_col, b_row, out_ready,
        input  busy, in_ready, out_valid, c_flat, ovf
    );

    modport slave (
        input  enable, start, k_len, in_valid, a_col, b_row, out_ready,
        output busy, in_ready, out_valid, c_flat, ovf
    );
endinterface

// File: rtl/systolic_array_nxn.sv
// Output-stationary NxN systolic matrix multiplier, C = A x B with per-job K.
// Define SYSTOLIC_SAT_EN for saturating accumulators with a sticky ovf flag.
module systolic_array_nxn #(
    parameter int unsigned N      = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned K_MAX  = 16,
    parameter int unsigned ACC_W  = 20
) (
    input logic                 clk,
    input logic                 rst,
    systolic_array_nxn_if.slave bus
);
    localparam int unsigned KW = $clog2(K_MAX + 1);
    localparam int unsigned CW = $clog2(2 * N);
    localparam int unsigned PW = 2 * DATA_W;
`ifdef SYSTOLIC_SAT_EN
    localparam int unsigned SW = ACC_W + 1;
`else
    localparam int unsigned SW = ACC_W;
`endif

    typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [KW-1:0]     k_q, k_d, beat_q, beat_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d, rdy_q, rdy_d, out_valid_q, out_valid_d;
`ifdef SYSTOLIC_SAT_EN
    logic              ovf_q, ovf_d;
`endif

    // Skew lines: row/column i holds i stages, so only [i][0..i-1] matter.
    logic [DATA_W-1:0] a_sk_q [N][N-1];
    logic [DATA_W-1:0] a_sk_d [N][N-1];
    logic [DATA_W-1:0] b_sk_q [N][N-1];
    logic [DATA_W-1:0] b_sk_d [N][N-1];
    logic [DATA_W-1:0] a_q    [N][N-1];
    logic [DATA_W-1:0] a_d    [N][N-1];
    logic [DATA_W-1:0] b_q    [N-1][N];
    logic [DATA_W-1:0] b_d    [N-1][N];
    logic [ACC_W-1:0]  acc_q  [N][N];
    logic [ACC_W-1:0]  acc_d  [N][N];

    logic [DATA_W-1:0] a_tap  [N][N];
    logic [DATA_W-1:0] b_tap  [N][N];
    logic [DATA_W-1:0] pe_a   [N][N];
    logic [DATA_W-1:0] pe_b   [N][N];
    logic [PW-1:0]     prod   [N][N];
    logic [SW-1:0]     sum    [N][N];

    logic in_ready, accept, advance, clear;

    assign in_ready = rdy_q & bus.enable;
    assign accept   = bus.in_valid & in_ready;
    assign advance  = (state_q == StFeed) || (state_q == StDrain);
    assign clear    = (state_q == StIdle) && bus.start;

    // Non-accepted cycles inject zeros, so bubbles and drain add nothing.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_tap[i][0] = accept ? bus.a_col[i*DATA_W +: DATA_W] : '0;
            b_tap[i][0] = accept ? bus.b_row[i*DATA_W +: DATA_W] : '0;
            for (int s = 1; s < N; s++) begin
                a_tap[i][s] = a_sk_q[i][s-1];
                b_tap[i][s] = b_sk_q[i][s-1];
            end
        end
        for (int i = 0; i < N; i++) begin
            pe_a[i][0] = a_tap[i][i];
            pe_b[0][i] = b_tap[i][i];
            for (int j = 1; j < N; j++) begin
                pe_a[i][j] = a_q[i][j-1];
                pe_b[j][i] = b_q[j-1][i];
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                prod[i][j] = PW'(pe_a[i][j]) * PW'(pe_b[i][j]);
                sum[i][j]  = SW'(acc_q[i][j]) + SW'(prod[i][j]);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        a_sk_d  = a_sk_q;
        b_sk_d  = b_sk_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
`ifdef SYSTOLIC_SAT_EN
        ovf_d   = ovf_q;
`endif

        if (advance) begin
            for (int i = 0; i < N; i++) begin
                for (int s = 0; s < N - 1; s++) begin
                    a_sk_d[i][s] = a_tap[i][s];
                    b_sk_d[i][s] = b_tap[i][s];
                    a_d[i][s]    = pe_a[i][s];
                    b_d[s][i]    = pe_b[s][i];
                end
                for (int j = 0; j < N; j++) begin
`ifdef SYSTOLIC_SAT_EN
                    if (sum[i][j][ACC_W]) begin
                        acc_d[i][j] = '1;
                        ovf_d       = 1'b1;
                    end else begin
                        acc_d[i][j] = sum[i][j][ACC_W-1:0];
                    end
`else
                    acc_d[i][j] = sum[i][j];
`endif
                end
            end
        end

        if (clear) begin
            a_sk_d = '{default: '0};
            b_sk_d = '{default: '0};
            a_d    = '{default: '0};
            b_d    = '{default: '0};
            acc_d  = '{default: '0};
`ifdef SYSTOLIC_SAT_EN
            ovf_d  = 1'b0;
`endif
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    k_d     = bus.k_len;
                    beat_d  = '0;
                    state_d = (bus.k_len == '0) ? StDone : StFeed;
                end
            end
            StFeed: begin
                if (accept) begin
                    beat_d = beat_q + KW'(1);
                    if (beat_q == k_q - KW'(1)) begin
                        state_d = StDrain;
                        cnt_d   = CW'(2 * N - 1);
                    end
                end
            end
            StDrain: begin
                if (cnt_q == '0) state_d = StDone;
                else             cnt_d   = cnt_q - CW'(1);
            end
            StDone: begin
                if (out_valid_q && bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d      = (state_d != StIdle);
        rdy_d       = (state_d == StFeed);
        out_valid_d = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            k_q         <= '0;
            beat_q      <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            rdy_q       <= 1'b0;
            out_valid_q <= 1'b0;
            a_sk_q      <= '{default: '0};
            b_sk_q      <= '{default: '0};
            a_q         <= '{default: '0};
            b_q         <= '{default: '0};
            acc_q       <= '{default: '0};
`ifdef SYSTOLIC_SAT_EN
            ovf_q       <= 1'b0;
`endif
        end else if (bus.enable) begin
            state_q     <= state_d;
            k_q         <= k_d;
            beat_q      <= beat_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            rdy_q       <= rdy_d;
            out_valid_q <= out_valid_d;
            a_sk_q      <= a_sk_d;
            b_sk_q      <= b_sk_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
`ifdef SYSTOLIC_SAT_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    always_comb begin
        bus.c_flat = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                bus.c_flat[(i*N+j)*ACC_W +: ACC_W] = acc_q[i][j];
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
`ifdef SYSTOLIC_SAT_EN
    assign bus.ovf       = ovf_q;
`else
    assign bus.ovf       = 1'b0;
`endif
endmodule

// File: tb/tb_systolic_array_nxn.sv
// Directed bench: a 2x2 instance (ACC_W=20) and a 4x4 instance (ACC_W=18).
module tb_systolic_array_nxn;
    logic clk;
    logic rst;

    systolic_array_nxn_if #(.N(2), .DATA_W(8), .K_MAX(16), .ACC_W(20)) bus2 ();
    systolic_array_nxn_if #(.N(4), .DATA_W(8), .K_MAX(16), .ACC_W(18)) bus4 ();

    systolic_array_nxn #(.N(2), .DATA_W(8), .K_MAX(16), .ACC_W(20)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );
    systolic_array_nxn #(.N(4), .DATA_W(8), .K_MAX(16), .ACC_W(18)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][7:0]  a;
        logic [3:0][7:0]  b;
        logic [3:0][19:0] c;
        logic             bub;
    } vec_t;

    vec_t       tbl [4];
    logic [7:0] am [4][16];
    logic [7:0] bm [16][4];
    int         nchk;
    int         nerr;
    int         lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_c2(input string name, input logic [3:0][19:0] exp);
        for (int n = 0; n < 4; n++) chk(name, 32'(bus2.c_flat[n*20 +: 20]), 32'(exp[n]));
    endtask

    task automatic job2(input int k, input bit bub, input int gap, output int l);
        bus2.start = 1'b1;
        bus2.k_len = 5'(k);
        @(posedge clk); #1;
        bus2.start = 1'b0;
        for (int b = 0; b < k; b++) begin
            if (bub && b == 1) begin
                bus2.in_valid = 1'b0;
                bus2.a_col    = '1;
                bus2.b_row    = '1;
                @(posedge clk); #1;
            end
            bus2.in_valid = 1'b1;
            bus2.a_col    = {am[1][b], am[0][b]};
            bus2.b_row    = {bm[b][1], bm[b][0]};
            @(posedge clk); #1;
        end
        bus2.in_valid = 1'b0;
        bus2.a_col    = '0;
        bus2.b_row    = '0;
        l = 0;
        while (!bus2.out_valid && l < 200) begin
            @(posedge clk); #1;
            l++;
            if (gap != 0 && l == gap) begin
                bus2.enable = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                    l++;
                end
                bus2.enable = 1'b1;
            end
        end
    endtask

    task automatic job4(input int k, input bit bub, output int l);
        bus4.start = 1'b1;
        bus4.k_len = 5'(k);
        @(posedge clk); #1;
        bus4.start = 1'b0;
        for (int b = 0; b < k; b++) begin
            if (bub && $urandom_range(0, 1) == 1) begin
                bus4.in_valid = 1'b0;
                bus4.a_col    = '1;
                bus4.b_row    = '1;
                @(posedge clk); #1;
            end
            bus4.in_valid = 1'b1;
            for (int i = 0; i < 4; i++) begin
                bus4.a_col[i*8 +: 8] = am[i][b];
                bus4.b_row[i*8 +: 8] = bm[b][i];
            end
            @(posedge clk); #1;
        end
        bus4.in_valid = 1'b0;
        bus4.a_col    = '0;
        bus4.b_row    = '0;
        l = 0;
        while (!bus4.out_valid && l < 200) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic load2(input int t);
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 2; k++) begin
                am[i][k] = tbl[t].a[i*2+k];
                bm[i][k] = tbl[t].b[i*2+k];
            end
        end
    endtask

    initial begin
        nchk = 0;
        nerr = 0;
        tbl[0] = '{a: {8'd4, 8'd3, 8'd2, 8'd1}, b: {8'd8, 8'd7, 8'd6, 8'd5},
                   c: {20'd50, 20'd43, 20'd22, 20'd19}, bub: 1'b0};
        tbl[1] = '{a: {8'd2, 8'd0, 8'd0, 8'd2}, b: {8'd12, 8'd11, 8'd10, 8'd9},
                   c: {20'd24, 20'd22, 20'd20, 20'd18}, bub: 1'b0};
        tbl[2] = '{a: {4{8'd255}}, b: {4{8'd255}}, c: {4{20'd130050}}, bub: 1'b0};
        tbl[3] = '{a: {8'd1, 8'd0, 8'd1, 8'd1}, b: {8'd6, 8'd5, 8'd4, 8'd3},
                   c: {20'd6, 20'd5, 20'd10, 20'd8}, bub: 1'b1};

        rst = 1'b1;
        bus2.enable = 1'b1; bus2.start = 1'b0; bus2.k_len = '0; bus2.in_valid = 1'b0;
        bus2.a_col = '0; bus2.b_row = '0; bus2.out_ready = 1'b1;
        bus4.enable = 1'b1; bus4.start = 1'b0; bus4.k_len = '0; bus4.in_valid = 1'b0;
        bus4.a_col = '0; bus4.b_row = '0; bus4.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        chk("rst_busy", 32'(bus2.busy), 0);
        chk("rst_in_ready", 32'(bus2.in_ready), 0);
        chk("rst_out_valid", 32'(bus2.out_valid), 0);
        chk("rst_ovf", 32'(bus2.ovf), 0);
        chk("rst_c2", 32'(|bus2.c_flat), 0);
        chk("rst_c4", 32'(|bus4.c_flat), 0);

        for (int t = 0; t < 4; t++) begin
            load2(t);
            job2(2, tbl[t].bub, 0, lat);
            chk("tbl_latency", 32'(lat), 4);
            chk_c2("tbl_c", tbl[t].c);
            chk("tbl_ovf", 32'(bus2.ovf), 0);
            @(posedge clk); #1;
            chk("tbl_busy_after", 32'(bus2.busy), 0);
            chk("tbl_valid_after", 32'(bus2.out_valid), 0);
        end

        // 4x4 identity times B with bubbles: C == B
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                am[i][k] = (i == k) ? 8'd1 : 8'd0;
                bm[i][k] = 8'(i * 4 + k + 1);
            end
        end
        job4(4, 1'b1, lat);
        chk("ident_latency", 32'(lat), 8);
        for (int n = 0; n < 16; n++) chk("ident_c", 32'(bus4.c_flat[n*18 +: 18]), 32'(n + 1));
        @(posedge clk); #1;
        chk("ident_busy_after", 32'(bus4.busy), 0);

        // K=16, all 255: 1040400 wraps or saturates in 18 bits
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 16; k++) begin
                am[i][k] = 8'd255;
                bm[k][i] = 8'd255;
            end
        end
        job4(16, 1'b0, lat);
        chk("full_latency", 32'(lat), 8);
`ifdef SYSTOLIC_SAT_EN
        for (int n = 0; n < 16; n++) chk("full_c", 32'(bus4.c_flat[n*18 +: 18]), 262143);
        chk("full_ovf", 32'(bus4.ovf), 1);
`else
        for (int n = 0; n < 16; n++) chk("full_c", 32'(bus4.c_flat[n*18 +: 18]), 253968);
        chk("full_ovf", 32'(bus4.ovf), 0);
`endif
        @(posedge clk); #1;

        // k_len = 0: straight to DONE with cleared result, held under back-pressure
        bus2.out_ready = 1'b0;
        bus2.start     = 1'b1;
        bus2.k_len     = '0;
        @(posedge clk); #1;
        bus2.start = 1'b0;
        chk("k0_valid", 32'(bus2.out_valid), 1);
        chk("k0_busy", 32'(bus2.busy), 1);
        chk("k0_c", 32'(|bus2.c_flat), 0);
        for (int c = 0; c < 5; c++) begin
            bus2.start = 1'b1;
            bus2.k_len = 5'd2;
            @(posedge clk); #1;
            chk("k0_hold_valid", 32'(bus2.out_valid), 1);
            chk("k0_hold_c", 32'(|bus2.c_flat), 0);
        end
        bus2.start     = 1'b0;
        bus2.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("k0_release_valid", 32'(bus2.out_valid), 0);
        chk("k0_release_busy", 32'(bus2.busy), 0);

        // Async reset after 2 of 4 beats, then a clean job
        bus2.start = 1'b1;
        bus2.k_len = 5'd4;
        @(posedge clk); #1;
        bus2.start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bus2.in_valid = 1'b1;
            bus2.a_col    = {8'd9, 8'd7};
            bus2.b_row    = {8'd5, 8'd3};
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(bus2.busy), 0);
        chk("midrst_in_ready", 32'(bus2.in_ready), 0);
        chk("midrst_out_valid", 32'(bus2.out_valid), 0);
        chk("midrst_c", 32'(|bus2.c_flat), 0);
        bus2.in_valid = 1'b0;
        bus2.a_col    = '0;
        bus2.b_row    = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        load2(0);
        job2(2, 1'b0, 0, lat);
        chk("postrst_latency", 32'(lat), 4);
        chk_c2("postrst_c", tbl[0].c);
        @(posedge clk); #1;

        // Enable dropped for 3 cycles in DRAIN stretches latency by 3
        load2(0);
        job2(2, 1'b0, 2, lat);
        chk("stall_latency", 32'(lat), 7);
        chk_c2("stall_c", tbl[0].c);
        @(posedge clk); #1;
        chk("stall_busy_after", 32'(bus2.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
